fifo_arb_ctrl: RTL and testbench

FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

---
 rtl/fifo_arb_ctrl.sv | 156 +++++++++++++++
 tb/tb_fifo_arb_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_arb_ctrl.sv
// rtl/fifo_arb_ctrl.sv - round-robin multi-requester FIFO writer and single-outstanding FIFO reader
//
// Write side: NUM_REQ requesters (req_valid/req_data/req_ready) share one FIFO
// write port (wr/data_in). A registered round-robin pointer picks the granted
// requester combinationally. The source ID is stored alongside the payload.
// Read side: a two-state reader pops one word at a time (rd/data_out/empty).
// It presents the word to a valid/ready consumer (out_valid/out_ready/out_data/out_src).
// wr_count counts accepted writes and wraps at 16 bits.
//
// Ports:
//   clock, rst        - clock; synchronous active-high reset
//   req_valid/ready   - per-requester handshake, req_ready is one-hot or zero
//   req_data          - requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr, data_in, full - FIFO write strobe, {src_id, payload}, full flag
//   rd, data_out      - FIFO read strobe; data_out valid the cycle after rd
//   empty             - FIFO empty flag
//   out_*             - consumer output register and handshake
//   wr_count          - total accepted writes (wrapping)

module fifo_arb_ctrl #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int FW         = ID_W + DATA_WIDTH
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          wr,
    output logic [FW-1:0]                 data_in,
    input  logic                          full,
    output logic                          rd,
    input  logic [FW-1:0]                 data_out,
    input  logic                          empty,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]               out_src,
    output logic [15:0]                   wr_count
);

    // One extra bit so rr_ptr + offset never overflows before the modulo fold.
    localparam int CW = ID_W + 1;
    localparam logic [CW-1:0] NUM_REQ_C = CW'(NUM_REQ);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [15:0]           wr_count_q, wr_count_d;
    state_t                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]       out_src_q, out_src_d;

    logic                  gnt_found;
    logic [ID_W-1:0]       gnt_id;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic [CW-1:0]         cand;
    logic                  grant_ok;

    // Circular search from rr_ptr: the first valid candidate wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_data  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= NUM_REQ_C) begin
                cand = cand - NUM_REQ_C;
            end
            if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = cand[ID_W-1:0];
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == ID_W'(k)) begin
                gnt_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant_ok  = gnt_found && !full && !rst;
    assign req_ready = grant_ok ? (NUM_REQ'(1) << gnt_id) : '0;
    assign wr        = grant_ok;
    assign data_in   = {gnt_id, gnt_data};

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_ok) begin
            rr_ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
        wr_count_d = wr_count_q + {15'd0, wr};
    end

    // Reader: at most one read in flight. A new read is issued only when the
    // output register is free or is being drained this cycle.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rd          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (!empty && (!out_valid_q || out_ready)) begin
                    rd      = 1'b1;
                    state_d = S_PEND;
                end
            end
            S_PEND: begin
                out_data_d  = data_out[DATA_WIDTH-1:0];
                out_src_d   = data_out[FW-1:DATA_WIDTH];
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            rd = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            wr_count_q  <= '0;
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wr_count_q  <= wr_count_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// tb/tb_fifo_arb_ctrl.sv - self-checking bench for fifo_arb_ctrl
module tb_fifo_arb_ctrl;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int IW = 2;
    localparam int FW = IW + DW;

    logic              clock = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              wr;
    logic [FW-1:0]     data_in;
    logic              full;
    logic              rd;
    logic [FW-1:0]     data_out;
    logic              empty;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_src;
    logic [15:0]       wr_count;

    always #5 clock = ~clock;

    fifo_arb_ctrl #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
        .clock     (clock),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr        (wr),
        .data_in   (data_in),
        .full      (full),
        .rd        (rd),
        .data_out  (data_out),
        .empty     (empty),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .wr_count  (wr_count)
    );

    int tests = 0;
    int fails = 0;

    logic [FW-1:0] mem [16];
    int head = 0;
    int tail = 0;
    logic rd_s;

    typedef struct {
        logic [3:0]  rv;
        logic        fl;
        logic [3:0]  rdy;
        logic [15:0] cnt;
    } wvec_t;

    typedef struct {
        logic        rd;
        logic        ov;
        logic [FW-1:0] word;
    } rvec_t;

    wvec_t wv [15];
    rvec_t rv3 [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock; the FIFO model answers a read the cycle after rd.
    task automatic advance();
        rd_s = rd;
        @(posedge clock);
        #1;
        if (rd_s === 1'b1 && head < tail) begin
            data_out = mem[head];
            head++;
        end
        empty = (head >= tail);
    endtask

    task automatic push(input logic [FW-1:0] w);
        mem[tail] = w;
        tail++;
        empty = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        full = 1'b0;
        out_ready = 1'b0;
        head = 0;
        tail = 0;
        empty = 1'b1;
        @(negedge clock);
        advance();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] eid;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 8'hA0 + 8'(i);
        data_out = '0;

        // Reset state: requests pending and FIFO non-empty, still nothing moves.
        rst = 1'b1; req_valid = 4'b1111; full = 1'b0; out_ready = 1'b1;
        head = 0; tail = 0; push({2'd1, 8'h99});
        @(negedge clock);
        advance();
        @(negedge clock);
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_wr", wr, 1'b0);
        chk("rst_rd", rd, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_src", out_src, 2'd0);
        chk("rst_wr_count", wr_count, 16'd0);
        advance();

        // Write-side vectors: round robin, alternate pattern, full back-pressure.
        wv[0]  = '{4'b1111, 1'b0, 4'b0001, 16'd0};
        wv[1]  = '{4'b1111, 1'b0, 4'b0010, 16'd1};
        wv[2]  = '{4'b1111, 1'b0, 4'b0100, 16'd2};
        wv[3]  = '{4'b1111, 1'b0, 4'b1000, 16'd3};
        wv[4]  = '{4'b1111, 1'b0, 4'b0001, 16'd4};
        wv[5]  = '{4'b1010, 1'b0, 4'b0010, 16'd5};
        wv[6]  = '{4'b1010, 1'b0, 4'b1000, 16'd6};
        wv[7]  = '{4'b1010, 1'b0, 4'b0010, 16'd7};
        wv[8]  = '{4'b1010, 1'b0, 4'b1000, 16'd8};
        wv[9]  = '{4'b0001, 1'b1, 4'b0000, 16'd9};
        wv[10] = '{4'b0001, 1'b1, 4'b0000, 16'd9};
        wv[11] = '{4'b0001, 1'b1, 4'b0000, 16'd9};
        wv[12] = '{4'b0001, 1'b0, 4'b0001, 16'd9};
        wv[13] = '{4'b0000, 1'b0, 4'b0000, 16'd10};
        wv[14] = '{4'b0100, 1'b0, 4'b0100, 16'd10};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            req_valid = wv[i].rv;
            full = wv[i].fl;
            @(negedge clock);
            chk($sformatf("w%0d_req_ready", i), req_ready, wv[i].rdy);
            chk($sformatf("w%0d_wr", i), wr, |wv[i].rdy);
            chk($sformatf("w%0d_wr_count", i), wr_count, wv[i].cnt);
            chk($sformatf("w%0d_rd", i), rd, 1'b0);
            if (|wv[i].rdy) begin
                eid = 2'd0;
                for (int b = 0; b < NR; b++) if (wv[i].rdy[b]) eid = 2'(b);
                chk($sformatf("w%0d_data_in", i), data_in, {eid, 8'hA0 + {6'd0, eid}});
            end
            advance();
        end

        // Three preloaded words drained with out_ready held high.
        rv3[0] = '{1'b1, 1'b0, 10'h000};
        rv3[1] = '{1'b0, 1'b0, 10'h000};
        rv3[2] = '{1'b1, 1'b1, {2'd2, 8'h11}};
        rv3[3] = '{1'b0, 1'b0, 10'h000};
        rv3[4] = '{1'b1, 1'b1, {2'd0, 8'h22}};
        rv3[5] = '{1'b0, 1'b0, 10'h000};
        rv3[6] = '{1'b0, 1'b1, {2'd3, 8'h33}};
        rv3[7] = '{1'b0, 1'b0, 10'h000};
        do_reset();
        push({2'd2, 8'h11});
        push({2'd0, 8'h22});
        push({2'd3, 8'h33});
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk($sformatf("r%0d_rd", i), rd, rv3[i].rd);
            chk($sformatf("r%0d_out_valid", i), out_valid, rv3[i].ov);
            if (rv3[i].ov) begin
                chk($sformatf("r%0d_out_data", i), out_data, rv3[i].word[DW-1:0]);
                chk($sformatf("r%0d_out_src", i), out_src, rv3[i].word[FW-1:DW]);
            end
            advance();
        end

        // Consumer stall: output held, no read, then resume reads same cycle.
        do_reset();
        push({2'd1, 8'h44});
        push({2'd3, 8'h55});
        @(negedge clock);
        chk("st_first_rd", rd, 1'b1);
        advance();
        @(negedge clock);
        chk("st_pend_rd", rd, 1'b0);
        advance();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("st%0d_rd", i), rd, 1'b0);
            chk($sformatf("st%0d_out_valid", i), out_valid, 1'b1);
            chk($sformatf("st%0d_out_data", i), out_data, 8'h44);
            chk($sformatf("st%0d_out_src", i), out_src, 2'd1);
            advance();
        end
        out_ready = 1'b1;
        @(negedge clock);
        chk("st_resume_rd", rd, 1'b1);
        chk("st_resume_ov", out_valid, 1'b1);
        advance();
        @(negedge clock);
        chk("st_drain_ov", out_valid, 1'b0);
        advance();
        @(negedge clock);
        chk("st_second_ov", out_valid, 1'b1);
        chk("st_second_data", out_data, 8'h55);
        chk("st_second_src", out_src, 2'd3);
        advance();

        // Reset during a pending read discards the word and clears the count.
        do_reset();
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            advance();
        end
        req_valid = 4'b0000;
        push({2'd2, 8'h77});
        out_ready = 1'b1;
        @(negedge clock);
        chk("pr_rd", rd, 1'b1);
        chk("pr_wr_count", wr_count, 16'd5);
        advance();
        rst = 1'b1;
        req_valid = 4'b1111;
        @(negedge clock);
        chk("pr_rst_rd", rd, 1'b0);
        chk("pr_rst_ready", req_ready, 4'b0000);
        chk("pr_rst_wr", wr, 1'b0);
        advance();
        rst = 1'b0;
        @(negedge clock);
        chk("pr_after_ov", out_valid, 1'b0);
        chk("pr_after_count", wr_count, 16'd0);
        chk("pr_after_data", out_data, 8'h00);
        chk("pr_after_ready", req_ready, 4'b0001);
        chk("pr_after_rd", rd, 1'b0);
        advance();
        req_valid = 4'b0000;
        @(negedge clock);
        chk("pr_no_stale_ov", out_valid, 1'b0);
        advance();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
